// File: rtl/power_mode_fsm.sv
// rtl/power_mode_fsm.sv - power-mode sequencer with settle, idle timeout, undervoltage fault and ADC duty cycle
module power_mode_fsm #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int IDLE_TIMEOUT   = 1024,
   parameter int RECOVER_CYCLES = 64,
   parameter int ADC_PERIOD     = 8,
   parameter int ADC_ON_CYCLES  = 2,
   parameter int LP_DIV         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       batt_low,
   input  logic       activity,
   input  logic       sleep_req,
   input  logic       wake_req,
   output logic [2:0] current_state,
   output logic       adc_enable,
   output logic       fault
);

   localparam int SETTLE_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
   localparam int IDLE_W    = (IDLE_TIMEOUT   > 1) ? $clog2(IDLE_TIMEOUT)   : 1;
   localparam int RECOVER_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam int PHASE_W   = (ADC_PERIOD     > 1) ? $clog2(ADC_PERIOD)     : 1;
   localparam int LP_W      = (LP_DIV         > 1) ? $clog2(LP_DIV)         : 1;

   localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0]    IDLE_LAST    = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [RECOVER_W-1:0] RECOVER_LAST = RECOVER_W'(RECOVER_CYCLES - 1);
   localparam logic [PHASE_W-1:0]   PHASE_LAST   = PHASE_W'(ADC_PERIOD - 1);
   localparam logic [PHASE_W-1:0]   ADC_ON       = PHASE_W'(ADC_ON_CYCLES);
   localparam logic [LP_W-1:0]      LP_LAST      = LP_W'(LP_DIV - 1);

   typedef enum logic [2:0] {
      ST_RESET     = 3'b000,
      ST_NORMAL    = 3'b001,
      ST_LOW_POWER = 3'b010,
      ST_FAULT     = 3'b011
   } state_t;

   state_t               state_q, state_d;
   logic                 batt_meta_q, batt_sync_q;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic [RECOVER_W-1:0] recover_q, recover_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [LP_W-1:0]      lp_q, lp_d;

   logic                 batt_low_s;
   logic                 phase_wrap;
   logic [PHASE_W-1:0]   phase_step;
   logic [LP_W-1:0]      lp_step;

   assign batt_low_s = batt_sync_q;

   // Free-running duty-cycle advance used while in NORMAL or LOW_POWER
   assign phase_wrap = (phase_q == PHASE_LAST);
   assign phase_step = phase_wrap ? '0 : phase_q + PHASE_W'(1);
   assign lp_step    = !phase_wrap ? lp_q :
                       (lp_q == LP_LAST) ? '0 : lp_q + LP_W'(1);

   // State register, counters and the two-flop undervoltage synchronizer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RESET;
         batt_meta_q <= 1'b0;
         batt_sync_q <= 1'b0;
         settle_q    <= '0;
         idle_q      <= '0;
         recover_q   <= '0;
         phase_q     <= '0;
         lp_q        <= '0;
      end else begin
         state_q     <= state_d;
         batt_meta_q <= batt_low;
         batt_sync_q <= batt_meta_q;
         settle_q    <= settle_d;
         idle_q      <= idle_d;
         recover_q   <= recover_d;
         phase_q     <= phase_d;
         lp_q        <= lp_d;
      end
   end

   // Next-state and next-counter decision; every state change clears all counters
   always_comb begin
      state_d   = state_q;
      settle_d  = '0;
      idle_d    = '0;
      recover_d = '0;
      phase_d   = '0;
      lp_d      = '0;
      case (state_q)
         ST_RESET: begin
            settle_d = settle_q + SETTLE_W'(1);
            if (batt_low_s) begin
               state_d = ST_FAULT;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = ST_NORMAL;
            end
         end
         ST_NORMAL: begin
            phase_d = phase_step;
            lp_d    = lp_step;
            if (batt_low_s) begin
               state_d = ST_FAULT;
            end else if (sleep_req) begin
               state_d = ST_LOW_POWER;
            end else if (activity) begin
               idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
               state_d = ST_LOW_POWER;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_LOW_POWER: begin
            phase_d = phase_step;
            lp_d    = lp_step;
            if (batt_low_s) begin
               state_d = ST_FAULT;
            end else if (activity || wake_req) begin
               state_d = ST_NORMAL;
            end
         end
         ST_FAULT: begin
            if (batt_low_s) begin
               recover_d = '0;
            end else if (recover_q == RECOVER_LAST) begin
               state_d = ST_RESET;
            end else begin
               recover_d = recover_q + RECOVER_W'(1);
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
      if (state_d != state_q) begin
         settle_d  = '0;
         idle_d    = '0;
         recover_d = '0;
         phase_d   = '0;
         lp_d      = '0;
      end
   end

   // Output decode from registered state and counters only
   always_comb begin
      current_state = state_q;
      fault         = (state_q == ST_FAULT);
      adc_enable    = 1'b0;
      case (state_q)
         ST_NORMAL:    adc_enable = (phase_q < ADC_ON);
         ST_LOW_POWER: adc_enable = (phase_q < ADC_ON) && (lp_q == '0);
         default:      adc_enable = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_power_mode_fsm.sv
// tb/tb_power_mode_fsm.sv - directed scoreboard bench for power_mode_fsm
module tb_power_mode_fsm;

   localparam logic [2:0] S_RST = 3'b000;
   localparam logic [2:0] S_NRM = 3'b001;
   localparam logic [2:0] S_LP  = 3'b010;
   localparam logic [2:0] S_FLT = 3'b011;

   logic       clk = 1'b0;
   logic       rst;
   logic       batt_low;
   logic       activity;
   logic       sleep_req;
   logic       wake_req;
   logic [2:0] current_state;
   logic       adc_enable;
   logic       fault;

   typedef struct {
      logic [2:0] st;
      logic       adc;
      logic       flt;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   power_mode_fsm #(
      .SETTLE_CYCLES (4),
      .IDLE_TIMEOUT  (8),
      .RECOVER_CYCLES(3),
      .ADC_PERIOD    (4),
      .ADC_ON_CYCLES (1),
      .LP_DIV        (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .batt_low     (batt_low),
      .activity     (activity),
      .sleep_req    (sleep_req),
      .wake_req     (wake_req),
      .current_state(current_state),
      .adc_enable   (adc_enable),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
         return;
      end
      e = exp_q.pop_front();
      n_tests++;
      assert (current_state === e.st) else begin
         n_fail++;
         $error("FAIL %s state: got %b expected %b", e.tag, current_state, e.st);
      end
      n_tests++;
      assert (adc_enable === e.adc) else begin
         n_fail++;
         $error("FAIL %s adc_enable: got %b expected %b", e.tag, adc_enable, e.adc);
      end
      n_tests++;
      assert (fault === e.flt) else begin
         n_fail++;
         $error("FAIL %s fault: got %b expected %b", e.tag, fault, e.flt);
      end
   endtask

   // Push the expectation for the edge about to happen, clock it, then compare
   task automatic cyc(input logic [2:0] st, input logic adc, input string tag);
      exp_t e;
      e.st  = st;
      e.adc = adc;
      e.flt = (st == S_FLT);
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      rst       = 1'b1;
      batt_low  = 1'b0;
      activity  = 1'b0;
      sleep_req = 1'b0;
      wake_req  = 1'b0;

      // Reset state, then startup settle of 4 cycles
      cyc(S_RST, 1'b0, "reset0");
      cyc(S_RST, 1'b0, "reset1");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(S_RST, 1'b0, "settle");

      // NORMAL entry and idle timeout with adc pattern 1,0,0,0,1,0,0,0
      for (int k = 0; k < 8; k++) cyc(S_NRM, (k % 4) == 0, "startup_normal");
      for (int j = 0; j < 9; j++) cyc(S_LP, ((j % 4) == 0) && (((j / 4) % 2) == 0), "lp_duty");

      // Wake, then idle timeout restarted by an activity pulse at cycle 5
      wake_req = 1'b1;
      cyc(S_NRM, 1'b1, "wake");
      wake_req = 1'b0;
      for (int k = 1; k < 5; k++) cyc(S_NRM, (k % 4) == 0, "idle_pre");
      activity = 1'b1;
      cyc(S_NRM, 1'b0, "activity_pulse");
      activity = 1'b0;
      for (int k = 6; k < 13; k++) cyc(S_NRM, (k % 4) == 0, "idle_post");
      cyc(S_LP, 1'b1, "timeout_after_activity");

      // Priority: sleep beats activity; activity+wake is a single transition
      wake_req = 1'b1;
      cyc(S_NRM, 1'b1, "wake2");
      wake_req  = 1'b0;
      sleep_req = 1'b1;
      activity  = 1'b1;
      cyc(S_LP, 1'b1, "sleep_beats_activity");
      sleep_req = 1'b0;
      wake_req  = 1'b1;
      cyc(S_NRM, 1'b1, "activity_and_wake");
      activity = 1'b0;
      wake_req = 1'b0;

      // Fault entry: 3 edges of latency, batt beats sleep, FAULT ignores requests
      batt_low = 1'b1;
      cyc(S_NRM, 1'b0, "batt_sync1");
      cyc(S_NRM, 1'b0, "batt_sync2");
      sleep_req = 1'b1;
      cyc(S_FLT, 1'b0, "fault_entry");
      wake_req = 1'b1;
      activity = 1'b1;
      cyc(S_FLT, 1'b0, "fault_ignore1");
      cyc(S_FLT, 1'b0, "fault_ignore2");
      sleep_req = 1'b0;
      wake_req  = 1'b0;
      activity  = 1'b0;

      // Recovery: 2 synced-low cycles, re-raise, then 3 synced-low cycles
      batt_low = 1'b0;
      cyc(S_FLT, 1'b0, "rec_a1");
      cyc(S_FLT, 1'b0, "rec_a2");
      batt_low = 1'b1;
      cyc(S_FLT, 1'b0, "rec_b1");
      cyc(S_FLT, 1'b0, "rec_b2");
      batt_low = 1'b0;
      for (int i = 0; i < 4; i++) cyc(S_FLT, 1'b0, "rec_c");
      for (int i = 0; i < 4; i++) cyc(S_RST, 1'b0, "rec_settle");
      cyc(S_NRM, 1'b1, "rec_normal");

      // Reset mid-operation from LOW_POWER with activity held
      sleep_req = 1'b1;
      cyc(S_LP, 1'b1, "lp_enter");
      sleep_req = 1'b0;
      cyc(S_LP, 1'b0, "lp_run1");
      cyc(S_LP, 1'b0, "lp_run2");
      rst      = 1'b1;
      activity = 1'b1;
      cyc(S_RST, 1'b0, "rst_mid");
      rst      = 1'b0;
      activity = 1'b0;
      for (int i = 0; i < 3; i++) cyc(S_RST, 1'b0, "rst_settle");
      for (int k = 0; k < 5; k++) cyc(S_NRM, (k % 4) == 0, "rst_normal");

      n_tests++;
      assert (exp_q.size() === 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: got %0d entries, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
